node_cmd_responder: RTL

NODE_CMD_RESPONDER -- requirements
Module: node_cmd_responder

---
 rtl/node_cmd_pkg.sv | 18 +
 rtl/node_rsp_fifo.sv | 62 ++++++
 rtl/node_cmd_responder.sv | 114 +++++++++++
 3 files changed

// File: rtl/node_cmd_pkg.sv
// Shared command encodings and register-file constants for the node command responder.
package node_cmd_pkg;

    typedef enum logic [1:0] {
        OP_PING  = 2'd0,
        OP_READ  = 2'd1,
        OP_WRITE = 2'd2,
        OP_RSVD  = 2'd3
    } cmd_op_e;

    localparam int NUM_REGS = 4;

    // Only the first NUM_REGS addresses are backed by registers.
    function automatic logic addr_in_range(input logic [7:0] addr);
        return (addr[7:2] == 6'd0);
    endfunction

endpackage

// File: rtl/node_rsp_fifo.sv
// Synchronous response queue: power-of-two depth, count-based full/empty, zeroed output when empty.
module node_rsp_fifo #(
    parameter int unsigned WIDTH = 17,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is never read while empty, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/node_cmd_responder.sv
// Command responder: PING/READ/WRITE against four local registers, one queued response per command.
// Optional build macro NODE_RSP_PARITY_EN adds the rsp_par output and a parity bit per queue entry.
module node_cmd_responder
    import node_cmd_pkg::*;
#(
    parameter logic [7:0]  NODE_ID    = 8'h00,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [7:0]        cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err
`ifdef NODE_RSP_PARITY_EN
    ,
    output logic              rsp_par
`endif
);
`ifdef NODE_RSP_PARITY_EN
    localparam int unsigned ENTRY_W = DATA_W + 2;

    function automatic logic even_parity(input logic [DATA_W:0] v);
        return ^v;
    endfunction
`else
    localparam int unsigned ENTRY_W = DATA_W + 1;
`endif

    logic [DATA_W-1:0]  regs_q [NUM_REGS];
    logic               ready_en_q;
    logic               fifo_full;
    logic               fifo_empty;
    logic               accept;
    logic               addr_ok;
    logic [1:0]         reg_idx;
    cmd_op_e            op;
    logic               reg_we;
    logic [DATA_W-1:0]  rsp_data_d;
    logic               rsp_err_d;
    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] head_entry;

    assign op        = cmd_op_e'(cmd_op);
    assign addr_ok   = addr_in_range(cmd_addr);
    assign reg_idx   = cmd_addr[1:0];
    // Ready is held low through reset and for the edge it is released on.
    assign cmd_ready = ready_en_q && !fifo_full;
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        rsp_data_d = '0;
        rsp_err_d  = 1'b0;
        reg_we     = 1'b0;
        case (op)
            OP_PING: rsp_data_d = DATA_W'(NODE_ID);
            OP_READ: begin
                if (addr_ok) rsp_data_d = regs_q[reg_idx];
                else         rsp_err_d  = 1'b1;
            end
            OP_WRITE: begin
                if (addr_ok) begin
                    rsp_data_d = cmd_wdata;
                    reg_we     = 1'b1;
                end else begin
                    rsp_err_d  = 1'b1;
                end
            end
            default: rsp_err_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en_q <= 1'b0;
            regs_q     <= '{default: '0};
        end else begin
            ready_en_q <= 1'b1;
            if (accept && reg_we) regs_q[reg_idx] <= cmd_wdata;
        end
    end

`ifdef NODE_RSP_PARITY_EN
    assign push_entry = {even_parity({rsp_err_d, rsp_data_d}), rsp_err_d, rsp_data_d};
    assign rsp_par    = head_entry[DATA_W+1];
`else
    assign push_entry = {rsp_err_d, rsp_data_d};
`endif

    node_rsp_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (accept),
        .wdata_i (push_entry),
        .pop_i   (rsp_ready),
        .rdata_o (head_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign rsp_valid = !fifo_empty;
    assign rsp_data  = head_entry[DATA_W-1:0];
    assign rsp_err   = head_entry[DATA_W];

endmodule
